// File: rtl/caliptra_fpga_log_pkg.sv
// rtl/caliptra_fpga_log_pkg.sv - shared constants for the FPGA firmware log path
package caliptra_fpga_log_pkg;

  localparam int LOG_CHAR_W = 8;

  // Host status word layout, consumed by the host-side register wrapper
  localparam int STS_EMPTY_BIT = 0;
  localparam int STS_FULL_BIT  = 1;
  localparam int STS_AFULL_BIT = 2;
  localparam int STS_OVF_BIT   = 3;
  localparam int STS_LEVEL_LSB = 16;
  localparam int STS_LEVEL_MSB = 31;

  function automatic logic [31:0] pack_status(input logic        empty,
                                              input logic        full,
                                              input logic        afull,
                                              input logic        ovf,
                                              input logic [15:0] level);
    logic [31:0] sts;
    sts = '0;
    sts[STS_EMPTY_BIT] = empty;
    sts[STS_FULL_BIT]  = full;
    sts[STS_AFULL_BIT] = afull;
    sts[STS_OVF_BIT]   = ovf;
    sts[STS_LEVEL_MSB:STS_LEVEL_LSB] = level;
    return sts;
  endfunction

endpackage

// File: rtl/caliptra_log_fifo_ram.sv
// rtl/caliptra_log_fifo_ram.sv - simple dual-port DEPTH x 8 storage, registered read
module caliptra_log_fifo_ram
  import caliptra_fpga_log_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [LOG_CHAR_W-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [LOG_CHAR_W-1:0] o_rdata
);

  logic [LOG_CHAR_W-1:0] r_mem [DEPTH];
  logic [LOG_CHAR_W-1:0] r_rdata;

  // Read returns the old word on a same-address write (full FIFO with push+pop)
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/caliptra_log_fifo.sv
// rtl/caliptra_log_fifo.sv - firmware log character FIFO with level/flags and sticky overflow
module caliptra_log_fifo
  import caliptra_fpga_log_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int AFULL_LVL = 768
) (
  input  logic                       core_clk,
  input  logic                       core_rst,
  input  logic [LOG_CHAR_W-1:0]      log_char,
  input  logic                       log_wr_en,
  input  logic                       rd_en,
  output logic [LOG_CHAR_W-1:0]      rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       afull,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr, r_rd_ptr, r_level;
  logic        r_empty, r_full, r_afull, r_overflow, r_rd_valid, r_rd_seen;

  logic [AW:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_level_nxt;
  logic        w_rd_accept, w_wr_accept, w_drop;
  logic [LOG_CHAR_W-1:0] w_ram_q;

  always_comb begin
    w_rd_accept  = rd_en && !r_empty;
    w_wr_accept  = log_wr_en && (!r_full || w_rd_accept);
    w_drop       = log_wr_en && r_full && !w_rd_accept;
    w_wr_ptr_nxt = w_wr_accept ? r_wr_ptr + (AW+1)'(1) : r_wr_ptr;
    w_rd_ptr_nxt = w_rd_accept ? r_rd_ptr + (AW+1)'(1) : r_rd_ptr;
    w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_level    <= w_level_nxt;
      r_empty    <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full     <= (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                    (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
      r_afull    <= (w_level_nxt >= (AW+1)'(AFULL_LVL));
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) r_rd_seen <= 1'b1;
      // A fresh drop outranks a same-cycle clear so no loss goes unreported
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  caliptra_log_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (core_clk),
    .i_we    (w_wr_accept && !core_rst),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (log_char),
    .i_re    (w_rd_accept && !core_rst),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_q)
  );

  // RAM output register is unreset; present zero until the first pop after reset
  assign rd_data  = r_rd_seen ? w_ram_q : '0;
  assign rd_valid = r_rd_valid;
  assign level    = r_level;
  assign empty    = r_empty;
  assign full     = r_full;
  assign afull    = r_afull;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_caliptra_log_fifo.sv
// tb/tb_caliptra_log_fifo.sv - scoreboard bench for caliptra_log_fifo
module tb_caliptra_log_fifo;

  localparam int DEPTH     = 1024;
  localparam int AFULL_LVL = 768;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          core_clk = 1'b0;
  logic          core_rst;
  logic [7:0]    log_char;
  logic          log_wr_en;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          empty, full, afull, overflow;
  logic          ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         model_ovf   = 1'b0;
  bit         exp_valid   = 1'b0;
  logic [7:0] exp_hold    = 8'h00;

  caliptra_log_fifo #(
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .core_clk  (core_clk),
    .core_rst  (core_rst),
    .log_char  (log_char),
    .log_wr_en (log_wr_en),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .afull     (afull),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is a plain queue with the FIFO's accept rules
  task automatic step(input bit rst, input bit wr, input logic [7:0] ch,
                      input bit rd, input bit clr);
    bit         was_full, racc, drop;
    logic [7:0] v;
    @(negedge core_clk);
    core_rst  = rst;
    log_wr_en = wr;
    log_char  = ch;
    rd_en     = rd;
    ovf_clr   = clr;
    drop      = 1'b0;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
      exp_valid = 1'b0;
      exp_hold  = 8'h00;
    end else begin
      was_full  = (model_q.size() == DEPTH);
      racc      = rd && (model_q.size() != 0);
      exp_valid = racc;
      if (racc) begin
        v = model_q.pop_front();
        exp_q.push_back(v);
        exp_hold = v;
      end
      if (wr) begin
        if (!was_full || racc) model_q.push_back(ch);
        else drop = 1'b1;
      end
      if (drop) model_ovf = 1'b1;
      else if (clr) model_ovf = 1'b0;
    end
    @(posedge core_clk);
    #1;
    check("level",    32'(level),    32'(model_q.size()));
    check("empty",    32'(empty),    32'(model_q.size() == 0));
    check("full",     32'(full),     32'(model_q.size() == DEPTH));
    check("afull",    32'(afull),    32'(model_q.size() >= AFULL_LVL));
    check("overflow", 32'(overflow), 32'(model_ovf));
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (!exp_valid) check("rd_data_hold", 32'(rd_data), 32'(exp_hold));
  endtask

  // Monitor: every rd_valid pulse consumes the oldest expected character
  initial begin
    forever begin
      @(posedge core_clk);
      #1;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: actual=%0h required=no pulse at %0t", rd_data, $time);
        end else begin
          check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bit wr, rd, clr;
    core_rst = 1'b1; log_wr_en = 1'b0; log_char = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;

    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);

    // 'H','i' then two pops
    step(0, 1, 8'h48, 0, 0);
    step(0, 1, 8'h69, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Fill to DEPTH, then one dropped write
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0, 0);
    step(0, 1, 8'hEE, 0, 0);

    // Clear racing a drop, then clear alone
    step(0, 1, 8'h11, 0, 1);
    step(0, 0, 8'h00, 0, 1);

    // Full FIFO: simultaneous push and pop, then full drain
    step(0, 1, 8'hAA, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Empty FIFO: simultaneous push and pop, then pop
    step(0, 1, 8'h55, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Reset with five stored and a pop requested
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hC0 + i), 0, 0);
    step(1, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 0);

    // Random traffic, long enough to carry both pointers past their wrap
    for (int i = 0; i < 3000; i++) begin
      wr  = ($urandom_range(99) < 85);
      rd  = ((i / 500) % 2 == 1) ? ($urandom_range(99) < 95) : ($urandom_range(99) < 40);
      clr = ($urandom_range(99) < 3);
      step(0, wr, 8'($urandom), rd, clr);
    end

    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    check("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
